// File: rtl/clock_pkg.sv
// Shared types and field limits for the century clock timekeeping logic.
package clock_pkg;

    // Set-mode states; encodings double as the edit_field output value.
    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_HOUR  = 3'd1,
        ST_SET_MIN   = 3'd2,
        ST_SET_DAY   = 3'd3,
        ST_SET_MONTH = 3'd4,
        ST_SET_YEAR  = 3'd5
    } state_e;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [4:0] HOUR_MAX  = 5'd23;
    localparam logic [3:0] MONTH_MAX = 4'd12;
    localparam logic [6:0] YEAR_MAX  = 7'd99;

endpackage

// File: rtl/cal_days_in_month.sv
// Days in a given month of a given year of the century (every 4th year is leap).
module cal_days_in_month (
    input  logic [3:0] month,
    input  logic [6:0] year,
    output logic [4:0] dim
);

    // Month length lookup with February leap adjustment
    always_comb begin
        dim = 5'd31;
        case (month)
            4'd2:                   dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            default:                dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_time_ctrl.sv
// Calendar timekeeping: seconds-to-year counter chain plus the time-set FSM.
module calendar_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned YEAR_RESET = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic [2:0] edit_field,
    output logic       blink
);

    state_e     state_q, state_d;
    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hour_q, hour_d, day_q, day_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q, year_d;
    logic       blink_q, blink_d;

    logic [3:0] month_inc;
    logic [6:0] year_inc;
    logic [3:0] cand_month;
    logic [6:0] cand_year;
    logic [4:0] dim_cur, dim_new;

    assign month_inc = (month_q == MONTH_MAX) ? 4'd1 : month_q + 4'd1;
    assign year_inc  = (year_q == YEAR_MAX) ? '0 : year_q + 7'd1;

    // The clamp must see the month length of the value about to be written
    assign cand_month = (state_q == ST_SET_MONTH) ? month_inc : month_q;
    assign cand_year  = (state_q == ST_SET_YEAR) ? year_inc : year_q;

    cal_days_in_month u_dim_cur (
        .month (month_q),
        .year  (year_q),
        .dim   (dim_cur)
    );

    cal_days_in_month u_dim_new (
        .month (cand_month),
        .year  (cand_year),
        .dim   (dim_new)
    );

    // Next-state: run-mode carry chain, set-mode editing and FSM stepping
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        blink_d = blink_q;

        if (state_q == ST_RUN) begin
            if (tick_1s) begin
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    if (min_q == MIN_MAX) begin
                        min_d = '0;
                        if (hour_q == HOUR_MAX) begin
                            hour_d = '0;
                            if (day_q == dim_cur) begin
                                day_d   = 5'd1;
                                month_d = month_inc;
                                if (month_q == MONTH_MAX) begin
                                    year_d = year_inc;
                                end
                            end else begin
                                day_d = day_q + 5'd1;
                            end
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
            // Applied after the tick so the clear wins over the increment
            if (btn_mode) begin
                state_d = ST_SET_HOUR;
                sec_d   = '0;
                blink_d = 1'b1;
            end
        end else begin
            if (tick_1s) begin
                blink_d = ~blink_q;
            end
            if (btn_mode) begin
                blink_d = 1'b1;
                case (state_q)
                    ST_SET_HOUR:  state_d = ST_SET_MIN;
                    ST_SET_MIN:   state_d = ST_SET_DAY;
                    ST_SET_DAY:   state_d = ST_SET_MONTH;
                    ST_SET_MONTH: state_d = ST_SET_YEAR;
                    default: begin
                        state_d = ST_RUN;
                        blink_d = 1'b0;
                    end
                endcase
            end else if (btn_inc) begin
                case (state_q)
                    ST_SET_HOUR: hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                    ST_SET_MIN:  min_d  = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
                    ST_SET_DAY:  day_d  = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
                    ST_SET_MONTH: begin
                        month_d = month_inc;
                        if (day_q > dim_new) day_d = dim_new;
                    end
                    default: begin
                        year_d = year_inc;
                        if (day_q > dim_new) day_d = dim_new;
                    end
                endcase
            end
        end
    end

    // State and time registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= 7'(YEAR_RESET);
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            blink_q <= blink_d;
        end
    end

    assign sec        = sec_q;
    assign min        = min_q;
    assign hour       = hour_q;
    assign day        = day_q;
    assign month      = month_q;
    assign year       = year_q;
    assign edit_field = state_q;
    assign blink      = blink_q;

endmodule

// File: doc/calendar_time_ctrl.md
# calendar_time_ctrl

Calendar timekeeping controller for the century clock. Consumes the one-cycle 1 s tick and debounced button pulses, and advances a seconds→year counter chain. It also runs the time-set state machine that lets the user edit hour, minute, day, month and year. It sits between the 1 s tick generator and the display/BCD decode logic.

## Interface
Parameters:
- YEAR_RESET, 0, year value (0–99) loaded at reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- tick_1s  in  1  one-cycle pulse, once per second
- btn_mode  in  1  one-cycle pulse, debounced upstream; advances set state
- btn_inc  in  1  one-cycle pulse, debounced upstream; increments the edited field
- sec  out  6  seconds 0–59
- min  out  6  minutes 0–59
- hour  out  5  hours 0–23
- day  out  5  day of month 1–31
- month  out  4  month 1–12
- year  out  7  year of century 0–99 (00 = 2000)
- edit_field  out  3  0 = none (RUN), 1 = hour, 2 = min, 3 = day, 4 = month, 5 = year
- blink  out  1  blink phase for the edited field; 0 in RUN

## Operation
- FSM states: RUN → SET_HOUR → SET_MIN → SET_DAY → SET_MONTH → SET_YEAR → RUN.
  - Each transition is triggered by btn_mode.
  - edit_field encodes the state.
- RUN:
  - On tick_1s, sec increments.
  - Carry chain: sec 59→0 carries to min, min 59→0 to hour, hour 23→0 to day.
  - day at days_in_month(month, year) → 1, carries to month.
  - month 12→1, carries to year.
  - year 99→0, no further carry.
  - btn_inc is ignored.
- Leap rule: year % 4 == 0 gives Feb = 29 days, otherwise 28. Months 4, 6, 9 and 11 have 30 days; the rest have 31.
- Entering SET_HOUR from RUN clears sec to 0 in the same cycle as the state change.
- Set states:
  - tick_1s does not advance time.
  - tick_1s toggles blink.
  - blink is forced to 1 on each state entry.
- btn_inc in a set state increments only the edited field, wrapping within its own range with no carry:
  - hour 23→0
  - min 59→0
  - day dim→1, where dim = days in the current month/year
  - month 12→1
  - year 99→0
- Day clamp: when month or year changes in a set state and day > new dim, day is set to dim in the same update.
- Leaving SET_YEAR returns to RUN. blink goes to 0 and timekeeping resumes on the next tick_1s.

## Timing
- All outputs are registered. Every update is visible the cycle after the triggering pulse.
- Reset values: sec 0, min 0, hour 0, day 1, month 1, year YEAR_RESET, state RUN, edit_field 0, blink 0.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: btn_mode wins and btn_inc is dropped.
  - tick_1s with btn_mode in RUN: the tick is applied and the state also advances. The sec clear overrides the tick increment.
  - tick_1s with btn_inc in a set state: the increment is applied and blink toggles.
- rst mid-set returns to RUN with reset values on the next edge. Pending button pulses in that cycle are ignored.
- Full rollover: 23:59:59 31/12/99 plus one tick gives 00:00:00 01/01/00 in a single cycle.

## Structure
- Package clock_pkg holds:
  - the state enum with explicit 3-bit encodings matching edit_field;
  - field max constants (59, 23, 12, 99).
- Sub-module cal_days_in_month: combinational, inputs month[3:0] and year[6:0], output dim[4:0]. It is shared by the carry chain and the clamp logic.

## Test plan
- Reset, then 61 ticks → sec = 1, min = 1, hour = 0, day = 1, month = 1, blink = 0.
- Preload 23:59:59 28/02/23, one tick → 00:00:00 01/03/23. Repeat with year 24 → 29/02/24.
- Preload 23:59:59 31/12/99, one tick → 00:00:00 01/01/00.
- In RUN with sec = 37, btn_mode → edit_field = 1, sec = 0, blink = 1.
  - 25 btn_inc → hour = 1.
  - Ticks toggle blink and leave sec = 0.
- Set day 31 and month 1, then 2 btn_inc in SET_MONTH with year 23 → month 3 via month 2, with day clamped to 28 at month 2.
- btn_mode and btn_inc together in SET_MIN → state SET_DAY, min unchanged.
  - Then assert rst mid-set → RUN, 00:00:00 01/01/YEAR_RESET.
